// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared definitions for the register-file arbiter.
//   state_t  - arbiter FSM state encoding (IDLE / WR / RD)
//   REQ_CORE - requester id of the core port (0)
//   REQ_DBG  - requester id of the debug port (1)
package reg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/reg_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin decision, purely combinational.
//   req0/req1 : requests from requester 0 / 1
//   ptr       : requester favoured when both request
//   valid     : at least one request present
//   id        : winning requester
module rr_arb2
  import reg_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic valid,
  output logic id
);

  always_comb begin
    valid = req0 | req1;
    id    = REQ_CORE;
    if (req0 && req1) begin
      id = ptr;
    end else if (req1) begin
      id = REQ_DBG;
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// reg_arbiter: arbitrates two requesters (core, debug) onto one register
// file. Each transaction takes a grant cycle (WR or RD) followed by an IDLE
// cycle carrying the ack, so the sustained rate is one per two cycles.
//   clk, rst                 : clock, async active-high reset
//   req*/we*/addr_*/wdata*   : per-requester transaction inputs
//   gnt0/gnt1                : grant, high for the WR/RD cycle
//   ack/ack_id/ack_we        : completion pulse with id and type
//   rdata_a/rdata_b          : read results, held until the next read
//   rf_*                     : register-file control and read data
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [AW-1:0]       addr_a0,
  input  logic [AW-1:0]       addr_a1,
  input  logic [AW-1:0]       addr_b0,
  input  logic [AW-1:0]       addr_b1,
  input  logic [DW-1:0]       wdata0,
  input  logic [DW-1:0]       wdata1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                ack,
  output logic                ack_id,
  output logic                ack_we,
  output logic [DW-1:0]       rdata_a,
  output logic [DW-1:0]       rdata_b,
  output logic                rf_en_in,
  output logic [(2**AW)-1:0]  rf_reg_en,
  output logic [DW-1:0]       rf_d_in,
  output logic [AW-1:0]       rf_rd,
  output logic [AW-1:0]       rf_rs,
  input  logic [DW-1:0]       rf_rd_q,
  input  logic [DW-1:0]       rf_rs_q
);

  localparam int NREG = 2**AW;

  state_t          state, state_nxt;
  logic            ptr;
  logic            win_valid, win_id;
  logic            sel_we;
  logic [AW-1:0]   sel_a, sel_b;
  logic [DW-1:0]   sel_wdata;
  logic            cur_id;
  logic [AW-1:0]   cur_a, cur_b;
  logic [DW-1:0]   cur_wdata;

  rr_arb2 u_rr (
    .req0  (req0),
    .req1  (req1),
    .ptr   (ptr),
    .valid (win_valid),
    .id    (win_id)
  );

  always_comb begin
    sel_we    = (win_id == REQ_DBG) ? we1     : we0;
    sel_a     = (win_id == REQ_DBG) ? addr_a1 : addr_a0;
    sel_b     = (win_id == REQ_DBG) ? addr_b1 : addr_b0;
    sel_wdata = (win_id == REQ_DBG) ? wdata1  : wdata0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_valid) state_nxt = sel_we ? WR : RD;
      WR, RD:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction capture at the grant edge, ack and read data at the edge
  // that closes WR/RD. The reset clears ack, so a reset inside RD never acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= REQ_CORE;
      cur_id    <= REQ_CORE;
      cur_a     <= '0;
      cur_b     <= '0;
      cur_wdata <= '0;
      ack       <= 1'b0;
      ack_id    <= 1'b0;
      ack_we    <= 1'b0;
      rdata_a   <= '0;
      rdata_b   <= '0;
    end else begin
      ack <= 1'b0;
      if (state == IDLE && win_valid) begin
        ptr       <= ~win_id;
        cur_id    <= win_id;
        cur_a     <= sel_a;
        cur_b     <= sel_b;
        cur_wdata <= sel_wdata;
      end
      if (state == WR || state == RD) begin
        ack    <= 1'b1;
        ack_id <= cur_id;
        ack_we <= (state == WR);
      end
      if (state == RD) begin
        rdata_a <= rf_rd_q;
        rdata_b <= rf_rs_q;
      end
    end
  end

  // Register-file and grant outputs are decoded from registered state only,
  // so an async reset into IDLE drops rf_reg_en immediately.
  always_comb begin
    gnt0      = (state != IDLE) && (cur_id == REQ_CORE);
    gnt1      = (state != IDLE) && (cur_id == REQ_DBG);
    rf_reg_en = '0;
    rf_d_in   = '0;
    rf_en_in  = 1'b0;
    rf_rd     = '0;
    rf_rs     = '0;
    if (state == WR) begin
      rf_reg_en[cur_a] = 1'b1;
      rf_d_in          = cur_wdata;
    end
    if (state == RD) begin
      rf_en_in = 1'b1;
      rf_rd    = cur_a;
      rf_rs    = cur_b;
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: self-checking bench for reg_arbiter with a behavioural
// 4-entry register file, a directed vector table, hand-written corner
// sequences and a random phase checked through an ack scoreboard.
module tb_reg_arbiter;

  localparam int DW = 16;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr_a0, addr_a1, addr_b0, addr_b1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, ack, ack_id, ack_we;
  logic [DW-1:0] rdata_a, rdata_b;
  logic          rf_en_in;
  logic [3:0]    rf_reg_en;
  logic [DW-1:0] rf_d_in;
  logic [AW-1:0] rf_rd, rf_rs;
  logic [DW-1:0] rf_rd_q, rf_rs_q;

  logic [DW-1:0] rf_mem [4] = '{default: '0};

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          r0, r1, we0, we1;
    logic [AW-1:0] a0, b0, a1, b1;
    logic [DW-1:0] d0, d1;
    logic          exp_id;
    logic [3:0]    exp_en;
    logic [DW-1:0] exp_ra, exp_rb;
  } vec_t;

  typedef struct {
    logic          id;
    logic          we;
    logic [DW-1:0] ra, rb;
  } ack_t;

  ack_t          sbq[$];
  logic          ptr_m;
  logic [DW-1:0] exp_rf [4];
  vec_t          tbl [9];

  reg_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr_a0(addr_a0), .addr_a1(addr_a1),
    .addr_b0(addr_b0), .addr_b1(addr_b1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ack(ack), .ack_id(ack_id), .ack_we(ack_we),
    .rdata_a(rdata_a), .rdata_b(rdata_b),
    .rf_en_in(rf_en_in), .rf_reg_en(rf_reg_en), .rf_d_in(rf_d_in),
    .rf_rd(rf_rd), .rf_rs(rf_rs),
    .rf_rd_q(rf_rd_q), .rf_rs_q(rf_rs_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rf_reg_en[i]) rf_mem[i] <= rf_d_in;
    end
  end
  assign rf_rd_q = rf_mem[rf_rd];
  assign rf_rs_q = rf_mem[rf_rs];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("rf_reg_en_onehot0", 32'($onehot0(rf_reg_en)), 32'd1);
      chk("rd_wr_exclusive", 32'(rf_en_in && (rf_reg_en != 4'b0)), 32'd0);
    end
  end

  function automatic vec_t mk(bit r0, bit w0, int a0, int b0, int d0,
                              bit r1, bit w1, int a1, int b1, int d1,
                              bit id, int en, int ra, int rb);
    vec_t v;
    v.r0 = r0; v.we0 = w0; v.a0 = AW'(a0); v.b0 = AW'(b0); v.d0 = DW'(d0);
    v.r1 = r1; v.we1 = w1; v.a1 = AW'(a1); v.b1 = AW'(b1); v.d1 = DW'(d1);
    v.exp_id = id; v.exp_en = 4'(en); v.exp_ra = DW'(ra); v.exp_rb = DW'(rb);
    return v;
  endfunction

  task automatic clear_in();
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr_a0 = '0; addr_a1 = '0; addr_b0 = '0; addr_b1 = '0;
    wdata0 = '0; wdata1 = '0;
  endtask

  task automatic drive(input vec_t v);
    req0 = v.r0; we0 = v.we0; addr_a0 = v.a0; addr_b0 = v.b0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.we1; addr_a1 = v.a1; addr_b1 = v.b1; wdata1 = v.d1;
  endtask

  task automatic check_ack();
    ack_t e;
    chk("ack", 32'(ack), 32'd1);
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: ack with empty queue at %0t", $time);
    end else begin
      e = sbq.pop_front();
      chk("ack_id", 32'(ack_id), 32'(e.id));
      chk("ack_we", 32'(ack_we), 32'(e.we));
      if (!e.we) begin
        chk("rdata_a", 32'(rdata_a), 32'(e.ra));
        chk("rdata_b", 32'(rdata_b), 32'(e.rb));
      end
    end
  endtask

  // One transaction: drive before the grant edge, check the WR/RD cycle,
  // then check the ack cycle against the scoreboard.
  task automatic issue(input vec_t v);
    ack_t          e;
    logic          w;
    logic [AW-1:0] a, b;
    logic [DW-1:0] d;
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    w = v.exp_id ? v.we1 : v.we0;
    a = v.exp_id ? v.a1  : v.a0;
    b = v.exp_id ? v.b1  : v.b0;
    d = v.exp_id ? v.d1  : v.d0;
    chk("gnt0", 32'(gnt0), 32'(v.exp_id == 1'b0));
    chk("gnt1", 32'(gnt1), 32'(v.exp_id == 1'b1));
    if (w) begin
      chk("wr_rf_reg_en", 32'(rf_reg_en), 32'(v.exp_en));
      chk("wr_rf_d_in", 32'(rf_d_in), 32'(d));
      chk("wr_rf_en_in", 32'(rf_en_in), 32'd0);
    end else begin
      chk("rd_rf_en_in", 32'(rf_en_in), 32'd1);
      chk("rd_rf_rd", 32'(rf_rd), 32'(a));
      chk("rd_rf_rs", 32'(rf_rs), 32'(b));
      chk("rd_rf_reg_en", 32'(rf_reg_en), 32'd0);
    end
    e.id = v.exp_id; e.we = w; e.ra = v.exp_ra; e.rb = v.exp_rb;
    sbq.push_back(e);
    clear_in();
    @(posedge clk);
    #1;
    chk("gnt_pulse", 32'({gnt0, gnt1}), 32'd0);
    check_ack();
    ptr_m = ~v.exp_id;
    if (w) exp_rf[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    ack_t e;
    logic [AW-1:0] wa, wb;

    clear_in();
    for (int i = 0; i < 4; i++) exp_rf[i] = '0;
    ptr_m = 1'b0;

    // Reset state, before any clock edge.
    #3;
    chk("rst_gnt0", 32'(gnt0), 0);        chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_ack", 32'(ack), 0);          chk("rst_ack_id", 32'(ack_id), 0);
    chk("rst_ack_we", 32'(ack_we), 0);    chk("rst_rf_en_in", 32'(rf_en_in), 0);
    chk("rst_rf_reg_en", 32'(rf_reg_en), 0);
    chk("rst_rf_d_in", 32'(rf_d_in), 0);  chk("rst_rf_rd", 32'(rf_rd), 0);
    chk("rst_rf_rs", 32'(rf_rs), 0);      chk("rst_rdata_a", 32'(rdata_a), 0);
    chk("rst_rdata_b", 32'(rdata_b), 0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a write to register 3.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr_a0 = 2'd3; wdata0 = 16'h1234;
    @(posedge clk);
    #1;
    chk("midwr_rf_reg_en", 32'(rf_reg_en), 32'b1000);
    clear_in();
    #2;
    rst = 1'b1;
    #1;
    chk("midwr_async_reg_en", 32'(rf_reg_en), 0);
    chk("midwr_async_gnt0", 32'(gnt0), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("midwr_no_ack", 32'(ack), 0);
    end
    ptr_m = 1'b0;

    // Directed table.       r0 w0 a0 b0 d0       r1 w1 a1 b1 d1       id en  ra       rb
    tbl[0] = mk(1, 0, 3, 3, 0,       0, 0, 0, 0, 0,       0, 0, 16'h0000, 16'h0000);
    tbl[1] = mk(1, 1, 2, 0, 16'hBEEF, 0, 0, 0, 0, 0,      0, 4'b0100, 0, 0);
    tbl[2] = mk(1, 0, 2, 0, 0,       0, 0, 0, 0, 0,       0, 0, 16'hBEEF, 16'h0000);
    tbl[3] = mk(1, 1, 1, 0, 16'h1111, 1, 1, 3, 0, 16'h3333, 1, 4'b1000, 0, 0);
    tbl[4] = mk(0, 0, 0, 0, 0,       1, 0, 3, 1, 0,       1, 0, 16'h3333, 16'h0000);
    tbl[5] = mk(0, 0, 0, 0, 0,       1, 1, 1, 0, 16'hAAAA, 1, 4'b0010, 0, 0);
    tbl[6] = mk(1, 0, 1, 2, 0,       1, 0, 0, 0, 0,       0, 0, 16'hAAAA, 16'hBEEF);
    tbl[7] = mk(1, 1, 0, 0, 16'h5555, 1, 1, 0, 0, 16'h6666, 1, 4'b0001, 0, 0);
    tbl[8] = mk(1, 0, 0, 3, 0,       0, 0, 0, 0, 0,       0, 0, 16'h6666, 16'h3333);
    for (int i = 0; i < 9; i++) issue(tbl[i]);

    // Contention from reset with both requests held continuously.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b1; addr_a0 = 2'd0; wdata0 = 16'h0A0A;
    req1 = 1'b1; we1 = 1'b1; addr_a1 = 2'd1; wdata1 = 16'h1B1B;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (k % 2 == 1) begin
        chk("cont_gnt0", 32'(gnt0), 32'(((k - 1) / 2) % 2 == 0));
        chk("cont_gnt1", 32'(gnt1), 32'(((k - 1) / 2) % 2 == 1));
        e.id = 1'(((k - 1) / 2) % 2); e.we = 1'b1; e.ra = '0; e.rb = '0;
        sbq.push_back(e);
      end else begin
        chk("cont_gnt_idle", 32'({gnt0, gnt1}), 0);
        check_ack();
      end
      if (k == 7) clear_in();
    end
    exp_rf[0] = 16'h0A0A;
    exp_rf[1] = 16'h1B1B;
    ptr_m = 1'b0;

    // Random traffic from both requesters.
    for (int n = 0; n < 60; n++) begin
      v.r0 = 1'($urandom_range(0, 1));  v.r1 = 1'($urandom_range(0, 1));
      v.we0 = 1'($urandom_range(0, 1)); v.we1 = 1'($urandom_range(0, 1));
      v.a0 = AW'($urandom_range(0, 3)); v.b0 = AW'($urandom_range(0, 3));
      v.a1 = AW'($urandom_range(0, 3)); v.b1 = AW'($urandom_range(0, 3));
      v.d0 = DW'($urandom);             v.d1 = DW'($urandom);
      if (!v.r0 && !v.r1) begin
        @(negedge clk);
        clear_in();
        @(posedge clk);
        #1;
        chk("rand_idle_gnt", 32'({gnt0, gnt1}), 0);
        chk("rand_idle_ack", 32'(ack), 0);
      end else begin
        v.exp_id = (v.r0 && v.r1) ? ptr_m : v.r1;
        wa = v.exp_id ? v.a1 : v.a0;
        wb = v.exp_id ? v.b1 : v.b0;
        v.exp_en = 4'b0001 << wa;
        v.exp_ra = exp_rf[wa];
        v.exp_rb = exp_rf[wb];
        issue(v);
      end
    end

    @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_arbiter.md
REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 SHALL have parameter DW, default 16: register data width.
REQ-002 SHALL have parameter AW, default 2: register address width. NREG = 2**AW (4) is derived, not a parameter.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, named clk and rst.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 req0/req1  in  1  transaction request, requester 0 (core) / 1 (debug).
REQ-007 we0/we1  in  1  1 = write, 0 = read.
REQ-008 addr_a0/addr_a1  in  AW  write address (write) or rd address (read).
REQ-009 addr_b0/addr_b1  in  AW  rs address (read only).
REQ-010 wdata0/wdata1  in  DW  write data.
REQ-011 gnt0/gnt1  out  1  grant, one-cycle pulse.
REQ-012 ack  out  1  completion pulse.
REQ-013 ack_id  out  1  requester served by ack.
REQ-014 ack_we  out  1  type of the completed transaction.
REQ-015 rdata_a/rdata_b  out  DW  read results, valid with ack when ack_we=0.
REQ-016 rf_en_in  out  1  register-file read enable.
REQ-017 rf_reg_en  out  NREG  one-hot register write enable.
REQ-018 rf_d_in  out  DW  register-file write data.
REQ-019 rf_rd/rf_rs  out  AW  register-file read addresses.
REQ-020 rf_rd_q/rf_rs_q  in  DW  register-file read data, combinational from rf_rd/rf_rs.

Function
REQ-021 FSM states SHALL be IDLE, WR and RD. IDLE -> WR or RD on a grant. WR -> IDLE and RD -> IDLE unconditionally after one cycle.
REQ-022 In IDLE, req0/req1 SHALL be sampled at each rising edge. A grant then latches the winner's we, addr_a, addr_b and wdata. After the grant edge, the requester's inputs are don't-care.
REQ-023 Arbitration SHALL be round-robin between the two requesters:
- a lone request always wins;
- simultaneous requests go to the requester the pointer favours;
- the pointer then favours the other requester.
REQ-024 gnt of the winner SHALL be high for exactly the WR/RD cycle. Requesters drop req at or before the edge ending that cycle; a req still high in IDLE is a new request.
REQ-025 In WR, outputs SHALL be: rf_reg_en = one-hot(addr_a), rf_d_in = wdata, rf_en_in = 0. The register captures at the edge ending WR.
REQ-026 In RD, outputs SHALL be: rf_en_in = 1, rf_rd = addr_a, rf_rs = addr_b, rf_reg_en = 0. At the edge ending RD, rf_rd_q/rf_rs_q are captured into rdata_a/rdata_b.
REQ-027 ack SHALL pulse for one cycle in the IDLE cycle after WR/RD, with ack_id and ack_we for that transaction. rdata_a/rdata_b hold their values until the next read completes.
REQ-028 All outputs SHALL be registered or decoded only from registered state. No combinational path from req/we/addr to rf_* or gnt.
REQ-029 Latency and throughput:
- grant edge to register write: 1 cycle;
- grant edge to ack: 1 cycle;
- one transaction per 2 cycles sustained, alternating requesters under contention.
REQ-030 Outside WR, rf_reg_en SHALL be 0. Outside RD, rf_en_in SHALL be 0. At most one rf_reg_en bit is ever high.
REQ-031 A read and a write SHALL never be issued in the same cycle. A read following a write to the same address returns the new value.

Reset
REQ-032 On rst, immediately and without clk:
- state = IDLE; round-robin pointer favours requester 0;
- gnt0/gnt1, ack, ack_id, ack_we, rf_en_in, rf_reg_en = 0;
- rf_d_in, rf_rd, rf_rs, rdata_a, rdata_b = 0.
REQ-033 Reset during WR SHALL deassert rf_reg_en before the next edge, so no register is written. Reset during RD SHALL produce no ack.
REQ-034 After rst deasserts, the first rising edge SHALL sample requests normally.

Structure
REQ-035 Shared package reg_arb_pkg SHALL hold the state encoding (IDLE/WR/RD) and the requester id constants (REQ_CORE = 0, REQ_DBG = 1).
REQ-036 The round-robin decision SHALL be a sub-module rr_arb2. Inputs: two requests and the pointer. Outputs: winner valid and winner id.

Verification
REQ-037 Write then read, requester 0 only:
- req0 we0=1 addr_a0=2 wdata0=0xBEEF -> gnt0 for 1 cycle, rf_reg_en=0100, ack (id 0, we 1);
- then read addr_a0=2 addr_b0=0 -> rdata_a=0xBEEF, rdata_b=0x0000.
REQ-038 Contention from reset: req0 and req1 both writing, held continuously:
- grants alternate 0,1,0,1 on cycles 1,3,5,7;
- ack_id sequence 0,1,0,1.
REQ-039 Lone requester 1 after a requester-1 grant -> granted again on the next IDLE edge; no dead cycle added.
REQ-040 rst asserted mid-WR (addr 3, data 0x1234) -> rf_reg_en=0 asynchronously; later read of register 3 returns 0x0000; no ack observed.
REQ-041 Random back-to-back reads/writes from both requesters against a scoreboard:
- rf_reg_en always 0 or one-hot;
- rf_en_in and rf_reg_en never both active;
- every ack matches the expected id, type and data.
